seg7_scan_capture: RTL and testbench
====================================

SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

Interface
REQ-001 Parameter STABLE_CYC, default 4, consecutive identical synchronized samples required before a digit is captured (legal range 1..255).
REQ-002 CLK  input  1  single clock; all state on rising edge.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 SEG  input  7  scanned segment lines, active-low, order gfedcba (bit0 = a).
REQ-005 DIG_N  input  4  digit strobes, active-low one-hot; bit k = digit k (k=0 least significant nibble).
REQ-006 VALUE  output  16  last complete frame; nibble k = digit k.
REQ-007 VALID  output  1  one-cycle pulse on VALUE update.
REQ-008 ERR  output  1  one-cycle pulse on illegal pattern or multi-hot strobe.
REQ-009 SEEN  output  4  per-digit captured-this-frame flags.

Function
REQ-010 SEG and DIG_N SHALL pass through a 2-flop synchronizer before any use.
REQ-011 Decode SHALL be this exact inverse map (SEG hex -> nibble): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 58->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-012 FSM states IDLE, SETTLE, HOLD.
REQ-013 IDLE: synchronized DIG_N all-high; stability counter held at 0.
REQ-014 IDLE->SETTLE when synchronized DIG_N has exactly one low bit; counter starts at 1.
REQ-015 SETTLE: counter increments each cycle that {DIG_N,SEG} equals the previous sample; any change restarts the counter at 1 (state remains SETTLE if still one-hot, else IDLE).
REQ-016 SETTLE->HOLD when counter reaches STABLE_CYC; in that same edge slot k is written with the decoded nibble and SEEN[k] set, if the pattern is legal.
REQ-017 HOLD: no further capture; exit to IDLE on all-high DIG_N, to SETTLE (counter=1) on any other change in {DIG_N,SEG}.
REQ-018 Exactly one capture per strobe period; re-capture of a digit already in SEEN overwrites its slot, no error.
REQ-019 Pattern 7F (blank) at capture point: no write, no SEEN change, no ERR.
REQ-020 Any other unmapped pattern at capture point: no write, no SEEN change, ERR pulses one cycle.
REQ-021 Multi-hot DIG_N (two or more low bits) sampled: treated as IDLE, ERR pulses once on entry to that condition.
REQ-022 When SEEN becomes 4'b1111, on the next edge VALUE loads all four slots atomically, VALID pulses one cycle, SEEN clears to 0.
REQ-023 Latency: stable input to slot write = 2 + STABLE_CYC cycles; final slot write to VALID = 1 cycle.
REQ-024 VALUE SHALL hold its value between frames; partial frames never update VALUE.
REQ-025 Capture of a new digit in the same cycle SEEN clears SHALL be recorded into the new frame (SEEN bit set after clear).

Reset
REQ-026 RST_N low at a rising edge: state IDLE, counter 0, synchronizer stages SEG=7F and DIG_N=F, slots 0, SEEN 0, VALUE 0, VALID 0, ERR 0.
REQ-027 Reset mid-frame SHALL discard all partial slots; first VALID after reset requires four fresh captures.

Configuration
REQ-028 Macro SEG7_SCAN_DP_EN: when defined, adds input SEG_DP (1 bit, active-low decimal point, synchronized like SEG, included in the stability comparison) and output DP (4 bits, active-high, DP[k] loaded with VALUE nibble k).
REQ-029 Without SEG7_SCAN_DP_EN: no SEG_DP/DP ports, no DP logic; behaviour otherwise identical.

Structure
REQ-030 Shared package seg7_pkg SHALL hold the sixteen 7-bit segment pattern constants, the blank constant 7F, and the FSM state enum typedef.
REQ-031 One sub-module seg7_pattern_dec: combinational 7-bit pattern -> {legal, blank, nibble[3:0]}, built from seg7_pkg constants.

Verification
REQ-032 Scan digits 0..3 with patterns 30,24,79,40 (3,2,1,0), 8 cycles each, STABLE_CYC=4 -> VALUE=16'h0123, single VALID pulse, SEEN back to 0.
REQ-033 Digit 2 strobe with SEG toggling every 3 cycles (STABLE_CYC=4) -> no capture, SEEN[2] stays 0, no ERR.
REQ-034 Digit 1 strobe with SEG=7'h7E held 8 cycles -> one ERR pulse, SEEN unchanged; SEG=7F -> no ERR, no capture.
REQ-035 DIG_N=4'b1100 held 6 cycles -> one ERR pulse, no capture, state IDLE.
REQ-036 Three digits captured, RST_N low one cycle, then full scan of 0E,06,21,46 -> VALUE=16'hCDEF only after all four post-reset captures.
REQ-037 With SEG7_SCAN_DP_EN, digit 0 scanned with SEG_DP=0, others 1 -> DP=4'b0001 coincident with VALID.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the scanned 7-segment capture block.
// Segment patterns are active-low, bit order gfedcba (bit0 = a).
package seg7_pkg;

  localparam logic [6:0] SEG_PAT_0 = 7'h40;
  localparam logic [6:0] SEG_PAT_1 = 7'h79;
  localparam logic [6:0] SEG_PAT_2 = 7'h24;
  localparam logic [6:0] SEG_PAT_3 = 7'h30;
  localparam logic [6:0] SEG_PAT_4 = 7'h19;
  localparam logic [6:0] SEG_PAT_5 = 7'h12;
  localparam logic [6:0] SEG_PAT_6 = 7'h02;
  localparam logic [6:0] SEG_PAT_7 = 7'h58;
  localparam logic [6:0] SEG_PAT_8 = 7'h00;
  localparam logic [6:0] SEG_PAT_9 = 7'h10;
  localparam logic [6:0] SEG_PAT_A = 7'h08;
  localparam logic [6:0] SEG_PAT_B = 7'h03;
  localparam logic [6:0] SEG_PAT_C = 7'h46;
  localparam logic [6:0] SEG_PAT_D = 7'h21;
  localparam logic [6:0] SEG_PAT_E = 7'h06;
  localparam logic [6:0] SEG_PAT_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } seg7_state_e;

  function automatic logic strobe_one_hot(input logic [3:0] dig_n);
    return $countones(~dig_n) == 1;
  endfunction

  function automatic logic strobe_multi_hot(input logic [3:0] dig_n);
    return $countones(~dig_n) >= 2;
  endfunction

  // Index of the lowest active (low) strobe bit; only meaningful when one-hot.
  function automatic logic [1:0] strobe_index(input logic [3:0] dig_n);
    logic [1:0] idx;
    idx = '0;
    for (int k = 3; k >= 0; k--) begin
      if (!dig_n[k]) idx = 2'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_dec.sv
// Combinational inverse map from an active-low segment pattern to a hex nibble,
// flagging legal digits and the all-dark blank pattern separately.
module seg7_pattern_dec
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic       legal_o,
  output logic       blank_o,
  output logic [3:0] nibble_o
);

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    legal_o  = 1'b1;
    blank_o  = 1'b0;
    nibble_o = 4'h0;
    unique case (pattern_i)
      SEG_PAT_0: nibble_o = 4'h0;
      SEG_PAT_1: nibble_o = 4'h1;
      SEG_PAT_2: nibble_o = 4'h2;
      SEG_PAT_3: nibble_o = 4'h3;
      SEG_PAT_4: nibble_o = 4'h4;
      SEG_PAT_5: nibble_o = 4'h5;
      SEG_PAT_6: nibble_o = 4'h6;
      SEG_PAT_7: nibble_o = 4'h7;
      SEG_PAT_8: nibble_o = 4'h8;
      SEG_PAT_9: nibble_o = 4'h9;
      SEG_PAT_A: nibble_o = 4'hA;
      SEG_PAT_B: nibble_o = 4'hB;
      SEG_PAT_C: nibble_o = 4'hC;
      SEG_PAT_D: nibble_o = 4'hD;
      SEG_PAT_E: nibble_o = 4'hE;
      SEG_PAT_F: nibble_o = 4'hF;
      SEG_BLANK: begin
        legal_o = 1'b0;
        blank_o = 1'b1;
      end
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Captures a multiplexed 4-digit 7-segment display bus into a 16-bit value.
// Optional decimal-point capture is enabled by defining SEG7_SCAN_DP_EN.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [6:0]  SEG,
  input  logic [3:0]  DIG_N,
`ifdef SEG7_SCAN_DP_EN
  input  logic        SEG_DP,
  output logic [3:0]  DP,
`endif
  output logic [15:0] VALUE,
  output logic        VALID,
  output logic        ERR,
  output logic [3:0]  SEEN
);

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYC);
`ifdef SEG7_SCAN_DP_EN
  localparam int SAMP_W = 12;
`else
  localparam int SAMP_W = 11;
`endif

  logic [6:0]        seg_s1_q, seg_s2_q;
  logic [3:0]        dig_s1_q, dig_s2_q;
  logic [SAMP_W-1:0] samp, prev_samp_q;
  seg7_state_e       state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              settled, changed, one_hot, multi_now, multi_prev;
  logic              dec_legal, dec_blank;
  logic [3:0]        dec_nibble;
  logic [1:0]        dig_idx;
  logic              cap_write, err_d, frame_done;
  logic [3:0][3:0]   slot_q;
  logic [3:0]        seen_q, seen_d;
  logic [15:0]       value_q;
  logic              valid_q, err_q;

  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      seg_s1_q <= SEG_BLANK;
      seg_s2_q <= SEG_BLANK;
      dig_s1_q <= 4'hF;
      dig_s2_q <= 4'hF;
    end else begin
      seg_s1_q <= SEG;
      seg_s2_q <= seg_s1_q;
      dig_s1_q <= DIG_N;
      dig_s2_q <= dig_s1_q;
    end
  end

`ifdef SEG7_SCAN_DP_EN
  logic       dp_s1_q, dp_s2_q;
  logic [3:0] dp_slot_q, dp_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      dp_s1_q   <= 1'b1;
      dp_s2_q   <= 1'b1;
      dp_slot_q <= '0;
      dp_q      <= '0;
    end else begin
      dp_s1_q <= SEG_DP;
      dp_s2_q <= dp_s1_q;
      if (cap_write) dp_slot_q[dig_idx] <= ~dp_s2_q;
      if (frame_done) dp_q <= dp_slot_q;
    end
  end

  assign DP   = dp_q;
  assign samp = {dp_s2_q, dig_s2_q, seg_s2_q};
`else
  assign samp = {dig_s2_q, seg_s2_q};
`endif

  assign changed    = (samp != prev_samp_q);
  assign one_hot    = strobe_one_hot(dig_s2_q);
  assign multi_now  = strobe_multi_hot(dig_s2_q);
  assign multi_prev = strobe_multi_hot(prev_samp_q[10:7]);
  assign dig_idx    = strobe_index(dig_s2_q);

  seg7_pattern_dec u_dec (
    .pattern_i (seg_s2_q),
    .legal_o   (dec_legal),
    .blank_o   (dec_blank),
    .nibble_o  (dec_nibble)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A settle that reaches the stability limit jumps straight to HOLD and captures.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    settled = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (one_hot) begin
          state_d = ST_SETTLE;
          cnt_d   = 8'd1;
        end
      end
      ST_SETTLE: begin
        if (!one_hot) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (changed) begin
          cnt_d = 8'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (!one_hot) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (changed) begin
          state_d = ST_SETTLE;
          cnt_d   = 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (state_d == ST_SETTLE && cnt_d == STABLE_LIM) begin
      state_d = ST_HOLD;
      settled = 1'b1;
    end
  end

  always_comb begin
    cap_write = settled && dec_legal;
    err_d     = (settled && !dec_legal && !dec_blank) || (multi_now && !multi_prev);
  end

  assign frame_done = (seen_q == 4'hF);

  // A capture landing on the clearing edge belongs to the next frame.
  always_comb begin
    seen_d = frame_done ? 4'h0 : seen_q;
    if (cap_write) seen_d[dig_idx] = 1'b1;
  end

  // NOTE: the slot storage is reset too, so a reset always starts from a clean frame.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      prev_samp_q <= '1;
      slot_q      <= '0;
      seen_q      <= '0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_samp_q <= samp;
      seen_q      <= seen_d;
      valid_q     <= frame_done;
      err_q       <= err_d;
      if (cap_write) slot_q[dig_idx] <= dec_nibble;
      if (frame_done) value_q <= slot_q;
    end
  end

  assign VALUE = value_q;
  assign VALID = valid_q;
  assign ERR   = err_q;
  assign SEEN  = seen_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed, scoreboard-based bench for seg7_scan_capture (STABLE_CYC = 4).
// Decimal-point checks are active when SEG7_SCAN_DP_EN is defined.
module tb_seg7_scan_capture;
  import seg7_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [6:0]  SEG;
  logic [3:0]  DIG_N;
  logic [15:0] VALUE;
  logic        VALID, ERR;
  logic [3:0]  SEEN;
`ifdef SEG7_SCAN_DP_EN
  logic        SEG_DP;
  logic [3:0]  DP;
`endif

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
  } frame_t;

  frame_t exp_q[$];
  int  check_cnt = 0, pass_cnt = 0, fail_cnt = 0;
  int  valid_cnt = 0, err_cnt = 0;
  bit  dp_mark = 1'b0;

  always #5 CLK = ~CLK;

  seg7_scan_capture #(.STABLE_CYC(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .SEG   (SEG),
    .DIG_N (DIG_N),
`ifdef SEG7_SCAN_DP_EN
    .SEG_DP(SEG_DP),
    .DP    (DP),
`endif
    .VALUE (VALUE),
    .VALID (VALID),
    .ERR   (ERR),
    .SEEN  (SEEN)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scan(input int k, input logic [6:0] s, input int n);
    DIG_N = ~(4'b0001 << k);
    SEG   = s;
`ifdef SEG7_SCAN_DP_EN
    SEG_DP = !(dp_mark && k == 0);
`endif
    repeat (n) @(negedge CLK);
  endtask

  task automatic idle(input int n);
    DIG_N = 4'hF;
    SEG   = 7'h7F;
`ifdef SEG7_SCAN_DP_EN
    SEG_DP = 1'b1;
`endif
    repeat (n) @(negedge CLK);
  endtask

  // Output monitor: counts pulses and pops the scoreboard on each VALID.
  always @(negedge CLK) begin : monitor
    frame_t f;
    if (ERR === 1'b1) err_cnt++;
    if (VALID === 1'b1) begin
      valid_cnt++;
      check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        f = exp_q.pop_front();
        check("frame_value", 32'(VALUE), 32'(f.value));
`ifdef SEG7_SCAN_DP_EN
        check("frame_dp", 32'(DP), 32'(f.dp));
`endif
      end
    end
  end

  initial begin
    int v0, e0;
    RST_N = 1'b0;
    DIG_N = 4'hF;
    SEG   = 7'h7F;
`ifdef SEG7_SCAN_DP_EN
    SEG_DP = 1'b1;
`endif
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    check("rst_value", 32'(VALUE), 32'h0);
    check("rst_valid", 32'(VALID), 32'h0);
    check("rst_err",   32'(ERR),   32'h0);
    check("rst_seen",  32'(SEEN),  32'h0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Full scan 3,2,1,0 with latency probes on the first and last digits.
    v0 = valid_cnt;
    e0 = err_cnt;
    dp_mark = 1'b1;
    scan(0, 7'h30, 5);
    check("lat_before_cap", 32'(SEEN), 32'h0);
    scan(0, 7'h30, 1);
    check("lat_at_cap", 32'(SEEN), 32'h1);
    scan(0, 7'h30, 2);
    dp_mark = 1'b0;
    scan(1, 7'h24, 8);
    scan(2, 7'h79, 8);
    check("seen_partial", 32'(SEEN), 32'h7);
    check("value_held_partial", 32'(VALUE), 32'h0);
    exp_q.push_back('{value: 16'h0123, dp: 4'b0001});
    scan(3, 7'h40, 6);
    check("seen_full", 32'(SEEN), 32'hF);
    check("valid_not_yet", 32'(VALID), 32'h0);
    scan(3, 7'h40, 1);
    check("valid_pulse", 32'(VALID), 32'h1);
    scan(3, 7'h40, 1);
    idle(6);
    check("scan_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("scan_seen_clear", 32'(SEEN), 32'h0);
    check("scan_value_hold", 32'(VALUE), 32'h0123);
    check("scan_no_err", 32'(err_cnt - e0), 32'd0);

    // Digit 2 with SEG toggling every 3 cycles never stabilises.
    e0 = err_cnt;
    for (int i = 0; i < 4; i++) scan(2, (i % 2 == 0) ? 7'h30 : 7'h24, 3);
    idle(4);
    check("toggle_seen", 32'(SEEN), 32'h0);
    check("toggle_no_err", 32'(err_cnt - e0), 32'd0);

    // Illegal pattern errors once; blank is silently ignored.
    e0 = err_cnt;
    scan(1, 7'h7E, 8);
    check("illegal_err", 32'(err_cnt - e0), 32'd1);
    check("illegal_seen", 32'(SEEN), 32'h0);
    e0 = err_cnt;
    scan(1, 7'h7F, 8);
    idle(4);
    check("blank_no_err", 32'(err_cnt - e0), 32'd0);
    check("blank_seen", 32'(SEEN), 32'h0);

    // Multi-hot strobe.
    e0 = err_cnt;
    DIG_N = 4'b1100;
    SEG   = 7'h30;
    repeat (6) @(negedge CLK);
    check("multi_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    idle(4);
    check("multi_err_once", 32'(err_cnt - e0), 32'd1);
    check("multi_seen", 32'(SEEN), 32'h0);

    // Re-capture of digit 0 overwrites its slot.
    v0 = valid_cnt;
    scan(0, 7'h79, 8);
    idle(3);
    scan(0, 7'h19, 8);
    check("recap_seen", 32'(SEEN), 32'h1);
    scan(1, 7'h12, 8);
    scan(2, 7'h02, 8);
    exp_q.push_back('{value: 16'h7654, dp: 4'b0000});
    scan(3, 7'h58, 8);
    idle(4);
    check("recap_valid_count", 32'(valid_cnt - v0), 32'd1);

    // Reset mid-frame discards partial slots.
    scan(0, 7'h00, 8);
    scan(1, 7'h10, 8);
    scan(2, 7'h08, 8);
    check("pre_rst_seen", 32'(SEEN), 32'h7);
    idle(1);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    idle(2);
    check("post_rst_seen", 32'(SEEN), 32'h0);
    check("post_rst_value", 32'(VALUE), 32'h0);
    v0 = valid_cnt;
    scan(0, 7'h0E, 8);
    scan(1, 7'h06, 8);
    scan(2, 7'h21, 8);
    check("post_rst_no_valid", 32'(valid_cnt - v0), 32'd0);
    exp_q.push_back('{value: 16'hCDEF, dp: 4'b0000});
    scan(3, 7'h46, 8);
    idle(4);
    check("post_rst_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("post_rst_value_final", 32'(VALUE), 32'hCDEF);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
